// File: rtl/led_mode_sequencer_pkg.sv
// Shared constants for the LED mode sequencer.
// Mode encoding, per-mode seed patterns, LED width.
package led_mode_sequencer_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] INIT_COUNT = 8'h00;
  localparam logic [LED_W-1:0] INIT_SCAN  = 8'h01;
  localparam logic [LED_W-1:0] INIT_BLINK = 8'hFF;

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    n = MODE_COUNT;
    unique case (m)
      MODE_COUNT: n = MODE_SCAN;
      MODE_SCAN:  n = MODE_BLINK;
      MODE_BLINK: n = MODE_HOLD;
      MODE_HOLD:  n = MODE_COUNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/led_mode_sequencer_button_debouncer.sv
// Pushbutton conditioner: 2-flop sync, debounce, press pulse.
// Ports: clock, reset_n, button (active-low raw), press (1-cycle).
module button_debouncer #(
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic press
);

  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE =
    {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic                     sync1;
  logic                     sync2;
  logic                     level;
  logic [DEBOUNCE_BITS-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // all-ones here means this is the 2^N-th differing clock
        if (&cnt) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-driven LED pattern sequencer (COUNT/SCAN/BLINK/HOLD).
// Ports: clock, reset_n, button in; leds, mode, step out.
module led_mode_sequencer
  import led_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int PRESCALE_BITS = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             button,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       mode,
  output logic             step
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE =
    {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  logic                     press;
  mode_e                    mode_q;
  dir_e                     dir;
  logic [LED_W-1:0]         pattern;
  logic [PRESCALE_BITS-1:0] pre;

  button_debouncer #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_btn (
    .clock  (clock),
    .reset_n(reset_n),
    .button (button),
    .press  (press)
  );

  assign step = &pre;
  assign mode = mode_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_COUNT;
      dir     <= DIR_LEFT;
      pattern <= INIT_COUNT;
      pre     <= '0;
      leds    <= '1;
    end else begin
      leds <= ~pattern;
      if (press) begin
        // a press swallows any coincident step
        pre    <= '0;
        mode_q <= next_mode(mode_q);
        unique case (mode_q)
          MODE_COUNT: begin
            pattern <= INIT_SCAN;
            dir     <= DIR_LEFT;
          end
          MODE_SCAN:  pattern <= INIT_BLINK;
          MODE_BLINK: ;
          MODE_HOLD:  pattern <= INIT_COUNT;
        endcase
      end else begin
        pre <= pre + PRE_ONE;
        if (step) begin
          unique case (mode_q)
            MODE_COUNT: pattern <= pattern + 8'd1;
            MODE_SCAN: begin
              if (dir == DIR_LEFT) begin
                pattern <= pattern << 1;
                if (pattern == 8'h40) dir <= DIR_RIGHT;
              end else begin
                pattern <= pattern >> 1;
                if (pattern == 8'h02) dir <= DIR_LEFT;
              end
            end
            MODE_BLINK: pattern <= ~pattern;
            MODE_HOLD:  ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_BITS, default 16: a new button level is accepted after it is stable for 2^DEBOUNCE_BITS clocks.
REQ-002 Parameter PRESCALE_BITS, default 24: the pattern step period is 2^PRESCALE_BITS clocks.
REQ-003 clock  input  1  single system clock (on-chip oscillator); all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 button  input  1  raw pushbutton, asynchronous to clock, active-low (0 = pressed).
REQ-006 leds  output  8  LED drive, active-low, registered.
REQ-007 mode  output  2  current display mode, registered: 0=COUNT, 1=SCAN, 2=BLINK, 3=HOLD.
REQ-008 step  output  1  one-cycle strobe marking each prescaler wrap, for observation.

Function
REQ-009 button SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Debouncer SHALL hold a debounced level and update it only after the synchronized input differs from that level for 2^DEBOUNCE_BITS consecutive clocks; any bounce SHALL restart the count.
REQ-011 press SHALL be a one-cycle pulse on a debounced 1->0 transition; release SHALL produce no event.
REQ-012 Prescaler SHALL be a free-running PRESCALE_BITS counter; step SHALL be 1 in the cycle the counter wraps from all-ones to 0.
REQ-013 Mode FSM SHALL advance COUNT->SCAN->BLINK->HOLD->COUNT, one state per press.
REQ-014 On a mode change, the pattern register SHALL load the new mode's initial value (COUNT 0x00, SCAN 0x01 with direction left, BLINK 0xFF, HOLD keeps current pattern) and the prescaler SHALL clear to 0.
REQ-015 COUNT: on step, pattern SHALL increment modulo 256 (0xFF -> 0x00).
REQ-016 SCAN: on step, one-hot pattern SHALL shift toward the current direction; on reaching 0x80 direction becomes right, on reaching 0x01 direction becomes left (sequence 01,02,...,80,40,...,01,02...).
REQ-017 BLINK: on step, pattern SHALL bitwise invert (0xFF <-> 0x00).
REQ-018 HOLD: pattern SHALL not change on step.
REQ-019 Press and step in the same cycle: press SHALL win; the step is discarded and REQ-014 applies.
REQ-020 leds SHALL equal ~pattern, registered one clock after the pattern register updates.
REQ-021 mode SHALL update in the clock after the press pulse.

Reset
REQ-022 reset_n low SHALL immediately force: leds 0xFF (all off), mode COUNT, step 0, pattern 0x00, SCAN direction left, prescaler 0, debounce counter 0, debounced level 1, synchronizer flops 1.
REQ-023 Reset asserted mid-debounce or mid-step SHALL discard the pending event; after release, a held-low button SHALL produce one press only after a full debounce interval.

Structure
REQ-024 A shared package SHALL hold the mode encoding constants, per-mode initial pattern constants, and the LED width (8).
REQ-025 Synchronizer, debounce counter and edge detector SHALL be one sub-module, button_debouncer, reused by other pushbutton inputs.
REQ-026 Prescaler, mode FSM and pattern datapath SHALL remain in led_mode_sequencer.

Verification (DEBOUNCE_BITS=2, PRESCALE_BITS=3)
REQ-027 Reset then idle 40 clocks -> leds 0xFF at reset; step every 8 clocks; leds 0xFE, 0xFD, 0xFC after first three steps.
REQ-028 button low for 3 clocks then high (bounce) -> no mode change; low held 8 clocks -> exactly one press, mode 1, leds 0xFE.
REQ-029 Mode SCAN, run 16 steps -> pattern 02,04,...,80,40,...,01,02 (leds inverse), direction reverses at both ends.
REQ-030 Three presses from COUNT -> mode 3; pattern frozen over 5 steps; fourth press -> mode 0, leds 0xFF, first step 8 clocks later.
REQ-031 Press pulse timed to coincide with step -> no pattern step applied, new mode initial value loaded, prescaler 0.
REQ-032 reset_n pulsed low asynchronously mid-BLINK with button held low -> outputs at reset values immediately; one press after release and 4+ clocks, mode 1.
